// File: rtl/data_memory_if.sv
// Bus between the MEM stage and the data RAM: byte address, write data,
// read/write strobes and the combinational read word.
interface data_memory_if;
    logic [31:0] Address;
    logic [31:0] WriteData;
    logic        MemWrite;
    logic        MemRead;
    logic [31:0] ReadData;

    modport master (
        output Address,
        output WriteData,
        output MemWrite,
        output MemRead,
        input  ReadData
    );

    modport slave (
        input  Address,
        input  WriteData,
        input  MemWrite,
        input  MemRead,
        output ReadData
    );
endinterface

// File: rtl/data_memory.sv
// Word-organised data RAM for the MEM stage: synchronous word writes,
// combinational gated reads, asynchronous active-low clear of the whole array.
module data_memory #(
    parameter int DEPTH     = 1024,
    parameter int ADDR_BITS = 10
) (
    input  logic         Clk,
    input  logic         Rst_n,
    data_memory_if.slave bus
);

    logic [31:0]          mem [DEPTH];
    logic [ADDR_BITS-1:0] wordIndex;
    logic                 inRange;
    logic [1:0]           unusedByteOffset;

    // Byte offset is dropped, so misaligned accesses hit the containing word.
    assign wordIndex        = bus.Address[ADDR_BITS+1:2];
    assign inRange          = (bus.Address[31:ADDR_BITS+2] == '0);
    assign unusedByteOffset = bus.Address[1:0];

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (bus.MemWrite && inRange) begin
            mem[wordIndex] <= bus.WriteData;
        end
    end

    // No write bypass: a same-word write only shows up after the edge.
    assign bus.ReadData = (bus.MemRead && Rst_n && inRange) ? mem[wordIndex] : 32'h0;

endmodule

// File: tb/tb_data_memory.sv
// Directed self-checking bench for data_memory: reset clearing, writes,
// zero-latency gated reads, misaligned/out-of-range addresses, read-during-write.
module tb_data_memory;

    logic Clk;
    logic Rst_n;
    int   checkCount;
    int   passCount;

    data_memory_if bus ();

    data_memory #(.DEPTH(1024), .ADDR_BITS(10)) dut (
        .Clk   (Clk),
        .Rst_n (Rst_n),
        .bus   (bus.slave)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic applyStimulus(input logic [31:0] addr, input logic [31:0] wdata,
                                 input logic we, input logic re);
        bus.Address   = addr;
        bus.WriteData = wdata;
        bus.MemWrite  = we;
        bus.MemRead   = re;
    endtask

    // Sample one tick after the inputs settle, never on a clock edge.
    task automatic checkOutput(input string tag, input logic [31:0] expected);
        #1;
        checkCount++;
        assert (bus.ReadData === expected) begin
            passCount++;
        end else begin
            $error("[TB] FAIL %s: observed %h expected %h", tag, bus.ReadData, expected);
        end
    endtask

    task automatic writeWord(input logic [31:0] addr, input logic [31:0] wdata);
        @(negedge Clk);
        applyStimulus(addr, wdata, 1'b1, 1'b0);
        @(posedge Clk);
        #1;
        applyStimulus(addr, wdata, 1'b0, 1'b0);
    endtask

    initial begin
        checkCount = 0;
        passCount  = 0;
        Rst_n      = 1'b0;
        applyStimulus(32'd8, 32'h0, 1'b0, 1'b1);
        checkOutput("initial_reset_read", 32'h0);
        @(negedge Clk);
        Rst_n = 1'b1;

        // Unwritten word after reset.
        applyStimulus(32'd32, 32'h0, 1'b0, 1'b1);
        checkOutput("unwritten_32", 32'h0);

        for (int i = 0; i < 5; i++) begin
            writeWord(32'(i * 4), 32'(i));
        end
        @(negedge Clk);
        for (int i = 4; i >= 0; i--) begin
            applyStimulus(32'(i * 4), 32'h0, 1'b0, 1'b1);
            checkOutput($sformatf("read_addr_%0d", i * 4), 32'(i));
        end

        applyStimulus(32'd32, 32'h0, 1'b0, 1'b1);
        checkOutput("unwritten_32_after_writes", 32'h0);

        applyStimulus(32'd4, 32'h0, 1'b0, 1'b0);
        checkOutput("memread_low", 32'h0);
        applyStimulus(32'd4, 32'h0, 1'b0, 1'b1);
        checkOutput("memread_raise", 32'h1);

        // MemWrite low across an edge must not disturb the array.
        @(negedge Clk);
        applyStimulus(32'd4, 32'hFFFF_FFFF, 1'b0, 1'b1);
        @(posedge Clk);
        checkOutput("no_write_when_disabled", 32'h1);

        writeWord(32'd6, 32'hDEAD_BEEF);
        applyStimulus(32'd4, 32'h0, 1'b0, 1'b1);
        checkOutput("misaligned_write_read4", 32'hDEAD_BEEF);
        applyStimulus(32'd7, 32'h0, 1'b0, 1'b1);
        checkOutput("misaligned_read7", 32'hDEAD_BEEF);
        applyStimulus(32'd8, 32'h0, 1'b0, 1'b1);
        checkOutput("neighbour_8_intact", 32'h2);

        writeWord(32'h0000_1000, 32'h5);
        applyStimulus(32'h0000_1000, 32'h0, 1'b0, 1'b1);
        checkOutput("out_of_range_read", 32'h0);
        applyStimulus(32'h0, 32'h0, 1'b0, 1'b1);
        checkOutput("out_of_range_no_alias", 32'h0);
        applyStimulus(32'h8000_0010, 32'h0, 1'b0, 1'b1);
        checkOutput("high_bit_out_of_range", 32'h0);

        // Read and write the same word in one cycle.
        @(negedge Clk);
        applyStimulus(32'd12, 32'd7, 1'b1, 1'b1);
        checkOutput("rw_before_edge", 32'h3);
        @(posedge Clk);
        checkOutput("rw_after_edge", 32'h7);
        applyStimulus(32'd12, 32'd0, 1'b0, 1'b1);

        // Mid-simulation reset, including a write attempted while held.
        @(negedge Clk);
        #2;
        Rst_n = 1'b0;
        applyStimulus(32'd8, 32'h0, 1'b0, 1'b1);
        checkOutput("read_during_reset", 32'h0);
        applyStimulus(32'd8, 32'h1234_5678, 1'b1, 1'b1);
        @(posedge Clk);
        checkOutput("write_blocked_in_reset", 32'h0);
        @(negedge Clk);
        applyStimulus(32'd8, 32'h0, 1'b0, 1'b1);
        Rst_n = 1'b1;
        checkOutput("addr8_after_reset", 32'h0);
        applyStimulus(32'd12, 32'h0, 1'b0, 1'b1);
        checkOutput("addr12_after_reset", 32'h0);
        applyStimulus(32'd4, 32'h0, 1'b0, 1'b1);
        checkOutput("addr4_after_reset", 32'h0);

        writeWord(32'd8, 32'hA5A5_5A5A);
        applyStimulus(32'd8, 32'h0, 1'b0, 1'b1);
        checkOutput("first_write_after_reset", 32'hA5A5_5A5A);

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
